// File: rtl/axi_pkg.sv
// AXI3 read-channel constants and the fixed-width AR attribute bundle,
// shared by the read-side arbiters and muxes.
package axi_pkg;
   localparam int LEN_W   = 4;
   localparam int SIZE_W  = 3;
   localparam int BURST_W = 2;
   localparam int LOCK_W  = 2;
   localparam int CACHE_W = 4;
   localparam int PROT_W  = 3;

   localparam logic PORT_I = 1'b0;
   localparam logic PORT_D = 1'b1;

   // Address and ID widths are per-instance parameters, so they live beside this struct.
   typedef struct packed {
      logic [LEN_W-1:0]   len;
      logic [SIZE_W-1:0]  size;
      logic [BURST_W-1:0] burst;
      logic [LOCK_W-1:0]  lock;
      logic [CACHE_W-1:0] cache;
      logic [PROT_W-1:0]  prot;
   } ar_chan_t;
endpackage

// File: rtl/axi_rd_arbiter_if.sv
// One AXI3 read port (AR + R channels). The master modport issues AR and
// accepts R; the slave modport is the opposite side.
interface axi_rd_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int ID_W   = 4
) ();
   import axi_pkg::*;

   logic [ID_W-1:0]    arid;
   logic [ADDR_W-1:0]  araddr;
   logic [LEN_W-1:0]   arlen;
   logic [SIZE_W-1:0]  arsize;
   logic [BURST_W-1:0] arburst;
   logic [LOCK_W-1:0]  arlock;
   logic [CACHE_W-1:0] arcache;
   logic [PROT_W-1:0]  arprot;
   logic               arvalid;
   logic               arready;

   logic [ID_W-1:0]    rid;
   logic [DATA_W-1:0]  rdata;
   logic [1:0]         rresp;
   logic               rlast;
   logic               rvalid;
   logic               rready;

   modport master (
      output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
      input  arready,
      input  rid, rdata, rresp, rlast, rvalid,
      output rready
   );

   modport slave (
      input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
      output arready,
      output rid, rdata, rresp, rlast, rvalid,
      input  rready
   );
endinterface

// File: rtl/axi_rd_arbiter_rr_arb2.sv
// Two-requester round-robin grant. The pointer names the favoured requester
// and moves to the loser whenever a grant is issued.
module rr_arb2
   import axi_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   output logic [1:0] gnt
);
   logic ptr_q, ptr_d;

   always_comb begin
      gnt   = 2'b00;
      ptr_d = ptr_q;
      case (req)
         2'b01:   gnt = 2'b01;
         2'b10:   gnt = 2'b10;
         2'b11:   gnt = ptr_q ? 2'b10 : 2'b01;
         default: gnt = 2'b00;
      endcase
      if (|gnt) ptr_d = ~gnt[PORT_D];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ptr_q <= PORT_I;
      else        ptr_q <= ptr_d;
   end
endmodule

// File: rtl/axi_rd_arbiter.sv
// Shares one AXI3 read port between the instruction (I) and data (D) masters:
// round-robin AR grant into a one-entry AR register, R beats routed back by rid[0].
module axi_rd_arbiter
   import axi_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int ID_W   = 4
) (
   input  logic             aclk,
   input  logic             aresetn,
   axi_rd_arbiter_if.slave  port_i,
   axi_rd_arbiter_if.slave  port_d,
   axi_rd_arbiter_if.master m_axi,
   output logic             rerr
);
   logic              arvalid_q, arvalid_d;
   ar_chan_t          ar_q, ar_d;
   logic [ADDR_W-1:0] araddr_q, araddr_d;
   logic [ID_W-1:0]   arid_q, arid_d;
   logic              pending_i_q, pending_i_d;
   logic              pending_d_q, pending_d_d;
   logic [ID_W-1:0]   saved_id_i_q, saved_id_i_d;
   logic [ID_W-1:0]   saved_id_d_q, saved_id_d_d;
   logic              rerr_q, rerr_d;

   logic [1:0]        req, gnt;
   logic              rsel, sel_pending, beat_done;
   logic [DATA_W-1:0] rdata_w;

   // Grants only happen into an empty AR register, so a drain and a grant never share a cycle.
   assign req[PORT_I] = port_i.arvalid & ~pending_i_q & ~arvalid_q;
   assign req[PORT_D] = port_d.arvalid & ~pending_d_q & ~arvalid_q;

   rr_arb2 u_rr_arb2 (
      .clk   (aclk),
      .rst_n (aresetn),
      .req   (req),
      .gnt   (gnt)
   );

   assign port_i.arready = gnt[PORT_I];
   assign port_d.arready = gnt[PORT_D];

   assign m_axi.arvalid = arvalid_q;
   assign m_axi.arid    = arid_q;
   assign m_axi.araddr  = araddr_q;
   assign m_axi.arlen   = ar_q.len;
   assign m_axi.arsize  = ar_q.size;
   assign m_axi.arburst = ar_q.burst;
   assign m_axi.arlock  = ar_q.lock;
   assign m_axi.arcache = ar_q.cache;
   assign m_axi.arprot  = ar_q.prot;

   // Beats for a port with nothing pending are orphans: accepted, dropped and flagged.
   assign rsel        = m_axi.rid[0];
   assign sel_pending = (rsel == PORT_D) ? pending_d_q : pending_i_q;
   assign m_axi.rready = sel_pending ? ((rsel == PORT_D) ? port_d.rready : port_i.rready) : 1'b1;
   assign beat_done   = m_axi.rvalid & m_axi.rready & m_axi.rlast & sel_pending;

   assign rdata_w      = m_axi.rdata;
   assign port_i.rvalid = m_axi.rvalid & (rsel == PORT_I) & pending_i_q;
   assign port_d.rvalid = m_axi.rvalid & (rsel == PORT_D) & pending_d_q;
   assign port_i.rdata  = rdata_w;
   assign port_d.rdata  = rdata_w;
   assign port_i.rresp  = m_axi.rresp;
   assign port_d.rresp  = m_axi.rresp;
   assign port_i.rlast  = m_axi.rlast;
   assign port_d.rlast  = m_axi.rlast;
   assign port_i.rid    = saved_id_i_q;
   assign port_d.rid    = saved_id_d_q;

   assign rerr = rerr_q;

   always_comb begin
      arvalid_d    = arvalid_q;
      ar_d         = ar_q;
      araddr_d     = araddr_q;
      arid_d       = arid_q;
      pending_i_d  = pending_i_q;
      pending_d_d  = pending_d_q;
      saved_id_i_d = saved_id_i_q;
      saved_id_d_d = saved_id_d_q;
      rerr_d       = rerr_q | (m_axi.rvalid & ~sel_pending);

      if (arvalid_q && m_axi.arready) arvalid_d = 1'b0;
      if (beat_done && rsel == PORT_I) pending_i_d = 1'b0;
      if (beat_done && rsel == PORT_D) pending_d_d = 1'b0;

      if (gnt[PORT_I]) begin
         arvalid_d    = 1'b1;
         araddr_d     = port_i.araddr;
         ar_d         = '{len: port_i.arlen, size: port_i.arsize, burst: port_i.arburst,
                          lock: port_i.arlock, cache: port_i.arcache, prot: port_i.arprot};
         arid_d       = '0;
         arid_d[0]    = PORT_I;
         pending_i_d  = 1'b1;
         saved_id_i_d = port_i.arid;
      end else if (gnt[PORT_D]) begin
         arvalid_d    = 1'b1;
         araddr_d     = port_d.araddr;
         ar_d         = '{len: port_d.arlen, size: port_d.arsize, burst: port_d.arburst,
                          lock: port_d.arlock, cache: port_d.arcache, prot: port_d.arprot};
         arid_d       = '0;
         arid_d[0]    = PORT_D;
         pending_d_d  = 1'b1;
         saved_id_d_d = port_d.arid;
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         arvalid_q    <= 1'b0;
         ar_q         <= '0;
         araddr_q     <= '0;
         arid_q       <= '0;
         pending_i_q  <= 1'b0;
         pending_d_q  <= 1'b0;
         saved_id_i_q <= '0;
         saved_id_d_q <= '0;
         rerr_q       <= 1'b0;
      end else begin
         arvalid_q    <= arvalid_d;
         ar_q         <= ar_d;
         araddr_q     <= araddr_d;
         arid_q       <= arid_d;
         pending_i_q  <= pending_i_d;
         pending_d_q  <= pending_d_d;
         saved_id_i_q <= saved_id_i_d;
         saved_id_d_q <= saved_id_d_d;
         rerr_q       <= rerr_d;
      end
   end
endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Bench for axi_rd_arbiter: directed scenarios plus randomized traffic, every cycle
// checked against a transaction-level model (AR slot queue, pending flags, saved IDs).
module tb_axi_rd_arbiter;
   import axi_pkg::*;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int IW = 4;

   logic aclk = 1'b0;
   logic aresetn = 1'b0;
   logic rerr;

   always #5 aclk = ~aclk;

   axi_rd_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .ID_W(IW)) ifi ();
   axi_rd_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .ID_W(IW)) ifd ();
   axi_rd_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .ID_W(IW)) ifm ();

   axi_rd_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ID_W(IW)) dut (
      .aclk    (aclk),
      .aresetn (aresetn),
      .port_i  (ifi),
      .port_d  (ifd),
      .m_axi   (ifm),
      .rerr    (rerr)
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      int          port;
      logic [AW-1:0] addr;
      logic [3:0]  len;
      logic [2:0]  size;
      logic [1:0]  burst;
      logic [1:0]  lock;
      logic [3:0]  cache;
      logic [2:0]  prot;
   } ar_rec_t;

   ar_rec_t       slot_q[$];
   bit            pend[2];
   logic [IW-1:0] saved[2];
   int            fav;
   bit            err;

   int      mwin;
   int      obs_gnt;
   bit      hs_dn;
   ar_rec_t dn_rec;
   bit      hs_r;

   task automatic model_clear();
      slot_q.delete();
      pend[0] = 0; pend[1] = 0;
      saved[0] = '0; saved[1] = '0;
      fav = 0; err = 0;
      mwin = -1; obs_gnt = -1; hs_dn = 0; hs_r = 0;
   endtask

   // One clock: check everything mid-cycle, advance the model, cross the edge.
   task automatic step();
      ar_rec_t r;
      bit ei, ed, rr_exp;
      int p, win;
      #4;
      win = -1;
      if (slot_q.size() == 0) begin
         ei = ifi.arvalid && !pend[0];
         ed = ifd.arvalid && !pend[1];
         if (ei && ed) win = fav;
         else if (ei)  win = 0;
         else if (ed)  win = 1;
      end
      chk("arready_i", 64'(ifi.arready), 64'(win == 0));
      chk("arready_d", 64'(ifd.arready), 64'(win == 1));
      chk("arvalid", 64'(ifm.arvalid), 64'(slot_q.size() != 0));
      if (slot_q.size() != 0) begin
         chk("arid",    64'(ifm.arid),    64'(slot_q[0].port));
         chk("araddr",  64'(ifm.araddr),  64'(slot_q[0].addr));
         chk("arlen",   64'(ifm.arlen),   64'(slot_q[0].len));
         chk("arattr",  64'({ifm.arsize, ifm.arburst, ifm.arlock, ifm.arcache, ifm.arprot}),
             64'({slot_q[0].size, slot_q[0].burst, slot_q[0].lock, slot_q[0].cache, slot_q[0].prot}));
      end
      p = ifm.rid[0] ? 1 : 0;
      rr_exp = pend[p] ? (p == 1 ? ifd.rready : ifi.rready) : 1'b1;
      chk("rready",   64'(ifm.rready), 64'(rr_exp));
      chk("rvalid_i", 64'(ifi.rvalid), 64'(ifm.rvalid && p == 0 && pend[0]));
      chk("rvalid_d", 64'(ifd.rvalid), 64'(ifm.rvalid && p == 1 && pend[1]));
      chk("rid_i", 64'(ifi.rid), 64'(saved[0]));
      chk("rid_d", 64'(ifd.rid), 64'(saved[1]));
      chk("rbeat_i", 64'({ifi.rdata, ifi.rresp, ifi.rlast}), 64'({ifm.rdata, ifm.rresp, ifm.rlast}));
      chk("rbeat_d", 64'({ifd.rdata, ifd.rresp, ifd.rlast}), 64'({ifm.rdata, ifm.rresp, ifm.rlast}));
      chk("rerr", 64'(rerr), 64'(err));
      obs_gnt = ifi.arready ? 0 : (ifd.arready ? 1 : -1);
      // next state
      hs_dn = 0;
      if (slot_q.size() != 0 && ifm.arready) begin
         hs_dn = 1;
         dn_rec = slot_q.pop_front();
      end
      hs_r = ifm.rvalid && rr_exp;
      if (ifm.rvalid && !pend[p]) err = 1;
      if (hs_r && ifm.rlast && pend[p]) pend[p] = 0;
      if (win >= 0) begin
         r.port = win;
         if (win == 0) begin
            r.addr = ifi.araddr; r.len = ifi.arlen; r.size = ifi.arsize; r.burst = ifi.arburst;
            r.lock = ifi.arlock; r.cache = ifi.arcache; r.prot = ifi.arprot; saved[0] = ifi.arid;
         end else begin
            r.addr = ifd.araddr; r.len = ifd.arlen; r.size = ifd.arsize; r.burst = ifd.arburst;
            r.lock = ifd.arlock; r.cache = ifd.arcache; r.prot = ifd.arprot; saved[1] = ifd.arid;
         end
         slot_q.push_back(r);
         pend[win] = 1;
         fav = 1 - win;
      end
      mwin = win;
      @(posedge aclk);
      #1;
   endtask

   // ---------------- stimulus ----------------
   bit       mv[2];
   bit       ob_act[2];
   int       ob_left[2];
   bit       rv;
   int       rcur;

   task automatic idle();
      ifi.arvalid = 0; ifi.arid = '0; ifi.araddr = '0; ifi.arlen = '0; ifi.arsize = '0;
      ifi.arburst = '0; ifi.arlock = '0; ifi.arcache = '0; ifi.arprot = '0; ifi.rready = 0;
      ifd.arvalid = 0; ifd.arid = '0; ifd.araddr = '0; ifd.arlen = '0; ifd.arsize = '0;
      ifd.arburst = '0; ifd.arlock = '0; ifd.arcache = '0; ifd.arprot = '0; ifd.rready = 0;
      ifm.arready = 0; ifm.rvalid = 0; ifm.rid = '0; ifm.rdata = '0; ifm.rresp = '0; ifm.rlast = 0;
      mv[0] = 0; mv[1] = 0; ob_act[0] = 0; ob_act[1] = 0; ob_left[0] = 0; ob_left[1] = 0;
      rv = 0; rcur = 0;
   endtask

   task automatic do_reset();
      aresetn = 1'b0;
      model_clear();
      @(posedge aclk);
      @(posedge aclk);
      #1;
      chk("rst_arvalid", 64'(ifm.arvalid), 64'd0);
      chk("rst_arfields", 64'({ifm.arid, ifm.araddr, ifm.arlen, ifm.arsize, ifm.arburst}), 64'd0);
      chk("rst_rerr", 64'(rerr), 64'd0);
      aresetn = 1'b1;
   endtask

   task automatic rnd_drive(input int p_req, input int p_ardy, input int p_rv,
                            input int p_rrdy, input int max_len);
      logic [IW-1:0] t;
      if (mwin >= 0) mv[mwin] = 0;
      if (hs_dn) begin
         ob_act[dn_rec.port] = 1;
         ob_left[dn_rec.port] = int'(dn_rec.len) + 1;
      end
      if (hs_r && rv) begin
         ob_left[rcur]--;
         if (ob_left[rcur] == 0) ob_act[rcur] = 0;
         rv = 0;
      end
      if (!mv[0] && $urandom_range(99) < p_req) begin
         mv[0] = 1;
         ifi.arid = IW'($urandom); ifi.araddr = $urandom; ifi.arlen = 4'($urandom_range(max_len));
         ifi.arsize = 3'($urandom); ifi.arburst = 2'($urandom); ifi.arlock = 2'($urandom);
         ifi.arcache = 4'($urandom); ifi.arprot = 3'($urandom);
      end
      if (!mv[1] && $urandom_range(99) < p_req) begin
         mv[1] = 1;
         ifd.arid = IW'($urandom); ifd.araddr = $urandom; ifd.arlen = 4'($urandom_range(max_len));
         ifd.arsize = 3'($urandom); ifd.arburst = 2'($urandom); ifd.arlock = 2'($urandom);
         ifd.arcache = 4'($urandom); ifd.arprot = 3'($urandom);
      end
      ifi.arvalid = mv[0];
      ifd.arvalid = mv[1];
      ifm.arready = ($urandom_range(99) < p_ardy);
      if (!rv && (ob_act[0] || ob_act[1]) && $urandom_range(99) < p_rv) begin
         if (ob_act[0] && ob_act[1]) rcur = int'($urandom_range(1));
         else rcur = ob_act[1] ? 1 : 0;
         rv = 1;
         t = IW'($urandom);
         t[0] = (rcur == 1);
         ifm.rid = t;
         ifm.rdata = $urandom;
         ifm.rresp = 2'($urandom);
         ifm.rlast = (ob_left[rcur] == 1);
      end
      ifm.rvalid = rv;
      ifi.rready = ($urandom_range(99) < p_rrdy);
      ifd.rready = ($urandom_range(99) < p_rrdy);
   endtask

   initial begin
      int last;
      idle();
      do_reset();

      // single fetch on port I
      ifi.arvalid = 1; ifi.arid = 4'd5; ifi.araddr = 32'h1FC0_0000; ifi.arlen = 4'd3;
      ifi.arsize = 3'd2; ifi.arburst = 2'd1; ifi.arcache = 4'd3; ifm.arready = 1;
      #1 chk("fetch_arready_i", 64'(ifi.arready), 64'd1);
      step();
      ifi.arvalid = 0;
      #1;
      chk("fetch_arvalid", 64'(ifm.arvalid), 64'd1);
      chk("fetch_arid", 64'(ifm.arid), 64'd0);
      chk("fetch_araddr", 64'(ifm.araddr), 64'h1FC0_0000);
      step();
      ifm.arready = 0;
      for (int b = 0; b < 4; b++) begin
         ifm.rvalid = 1; ifm.rid = '0; ifm.rdata = 32'h1000 + b; ifm.rlast = (b == 3); ifi.rready = 1;
         #1;
         chk("fetch_rvalid_i", 64'(ifi.rvalid), 64'd1);
         chk("fetch_rid_i", 64'(ifi.rid), 64'd5);
         chk("fetch_rlast_i", 64'(ifi.rlast), 64'(b == 3));
         step();
      end
      ifm.rvalid = 0; ifm.rlast = 0; ifi.arvalid = 1;
      #1 chk("fetch_done_arready_i", 64'(ifi.arready), 64'd1);
      step();
      ifi.arvalid = 0;
      step();

      // simultaneous requests from reset
      idle();
      ifi.arvalid = 1; ifi.arid = 4'd2; ifi.araddr = 32'hA000_0010;
      ifd.arvalid = 1; ifd.arid = 4'd7; ifd.araddr = 32'hD000_0020;
      do_reset();
      step();
      ifi.arvalid = 0;
      #1;
      chk("sim_arid_i", 64'(ifm.arid), 64'd0);
      chk("sim_araddr_i", 64'(ifm.araddr), 64'hA000_0010);
      step();
      step();
      ifm.arready = 1;
      step();
      ifm.arready = 0;
      #1 chk("sim_arready_d", 64'(ifd.arready), 64'd1);
      step();
      ifd.arvalid = 0;
      #1;
      chk("sim_arid_d", 64'(ifm.arid), 64'd1);
      chk("sim_araddr_d", 64'(ifm.araddr), 64'hD000_0020);
      step();

      // round-robin with continuous single-beat traffic
      idle();
      do_reset();
      last = -1;
      for (int c = 0; c < 60; c++) begin
         rnd_drive(100, 100, 100, 100, 0);
         step();
         if (obs_gnt >= 0) begin
            if (last >= 0) chk("rr_alternate", 64'(obs_gnt), 64'(1 - last));
            last = obs_gnt;
         end
      end

      // blocking: port I re-requests while its burst is pending
      idle();
      do_reset();
      ifi.arvalid = 1; ifi.arid = 4'd3; ifi.araddr = 32'h0000_4000; ifi.arlen = 4'd1; ifm.arready = 1;
      step();
      step();
      ifm.arready = 0;
      for (int c = 0; c < 3; c++) begin
         #1 chk("blk_arready_i", 64'(ifi.arready), 64'd0);
         step();
      end
      ifm.rvalid = 1; ifm.rid = '0; ifm.rlast = 0; ifi.rready = 1;
      #1 chk("blk_arready_i_beat0", 64'(ifi.arready), 64'd0);
      step();
      ifm.rlast = 1;
      #1 chk("blk_arready_i_last", 64'(ifi.arready), 64'd0);
      step();
      ifm.rvalid = 0; ifm.rlast = 0;
      #1 chk("blk_arready_i_after", 64'(ifi.arready), 64'd1);
      step();
      ifi.arvalid = 0;
      step();

      // D burst returned while rready_d is low
      idle();
      do_reset();
      ifd.arvalid = 1; ifd.arid = 4'd9; ifd.araddr = 32'h8000_0100; ifd.arlen = 4'd1; ifm.arready = 1;
      step();
      ifd.arvalid = 0;
      step();
      ifm.arready = 0;
      ifm.rvalid = 1; ifm.rid = 4'b0111; ifm.rdata = 32'hCAFE_0001; ifm.rlast = 0;
      ifd.rready = 0; ifi.rready = 1;
      for (int c = 0; c < 3; c++) begin
         #1;
         chk("stall_rready", 64'(ifm.rready), 64'd0);
         chk("stall_rvalid_i", 64'(ifi.rvalid), 64'd0);
         chk("stall_rvalid_d", 64'(ifd.rvalid), 64'd1);
         chk("stall_rdata_d", 64'(ifd.rdata), 64'hCAFE_0001);
         step();
      end
      ifd.rready = 1;
      step();
      ifm.rdata = 32'hCAFE_0002; ifm.rlast = 1;
      step();
      ifm.rvalid = 0; ifm.rlast = 0;
      #1 chk("stall_rid_d", 64'(ifd.rid), 64'd9);
      step();

      // orphan beat, then asynchronous reset mid-burst
      idle();
      do_reset();
      ifm.rvalid = 1; ifm.rid = 4'd1; ifm.rlast = 1; ifd.rready = 0;
      #1;
      chk("orph_rready", 64'(ifm.rready), 64'd1);
      chk("orph_rvalid_d", 64'(ifd.rvalid), 64'd0);
      step();
      ifm.rvalid = 0; ifm.rlast = 0;
      #1 chk("orph_rerr", 64'(rerr), 64'd1);
      step();
      step();
      #1 chk("orph_rerr_sticky", 64'(rerr), 64'd1);
      ifi.arvalid = 1; ifi.arid = 4'd4; ifi.araddr = 32'h0000_8000; ifi.arlen = 4'd3; ifm.arready = 1;
      step();
      ifi.arvalid = 0;
      step();
      ifm.arready = 0; ifm.rvalid = 1; ifm.rid = '0; ifm.rlast = 0; ifi.rready = 1;
      step();
      #2 aresetn = 1'b0;
      model_clear();
      #1;
      chk("arst_arvalid", 64'(ifm.arvalid), 64'd0);
      chk("arst_rerr", 64'(rerr), 64'd0);
      chk("arst_rvalid_i", 64'(ifi.rvalid), 64'd0);
      chk("arst_rready", 64'(ifm.rready), 64'd1);
      idle();
      do_reset();

      // randomized traffic in segments with varied handshake pressure
      for (int s = 0; s < 10; s++) begin
         int pq, pa, pv, pr, ml;
         pq = int'($urandom_range(20, 100));
         pa = int'($urandom_range(20, 100));
         pv = int'($urandom_range(20, 100));
         pr = int'($urandom_range(20, 100));
         ml = int'($urandom_range(0, 15));
         for (int c = 0; c < 200; c++) begin
            rnd_drive(pq, pa, pv, pr, ml);
            step();
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/axi_rd_arbiter.md
Name: axi_rd_arbiter

Overview:
- Shares one AXI3 read port (AR + R channels) between the instruction-side master (port I) and the data-side master (port D).
- Sits between the instruction and data subsystem tops and the external AXI interconnect.
- Arbitrates AR requests round-robin through a registered AR output stage.
- Tags each burst with its port number and routes R beats back by ID.
- Each port may have at most one outstanding burst.

Parameters:
- ADDR_W, 32, AR address width
- DATA_W, 32, R data width
- ID_W, 4, AXI ID width (must be ≥ 1)

Ports:
- aclk  in  1  clock
- aresetn  in  1  reset, asynchronous, active-low
- arid_i  in  ID_W  port I request ID; port I also has araddr_i (ADDR_W), arlen_i (4), arsize_i (3), arburst_i (2), arlock_i (2), arcache_i (4), arprot_i (3), arvalid_i (1) in; arready_i (1) out
- rid_i  out  ID_W  port I returned ID; port I also has rdata_i (DATA_W), rresp_i (2), rlast_i (1), rvalid_i (1) out; rready_i (1) in
- *_d  same set as port I, for port D
- arid  out  ID_W  downstream ID; downstream also has araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid out; arready in
- rid  in  ID_W  downstream R ID; downstream also has rdata, rresp, rlast, rvalid in; rready out
- rerr  out  1  sticky flag: an R beat arrived for a port with no pending burst

Behaviour:
- Reset (async assert, deasserted on aclk): clear the AR register (arvalid=0, all AR fields 0), pending_i/pending_d=0, rr_ptr=0 (I favoured), saved IDs=0, rerr=0. A reset mid-burst drops the burst silently.
- Eligibility: a port is eligible when its arvalid_x=1 and its registered pending_x=0.
- Grant rule: a grant occurs only when the AR register is empty (arvalid=0).
  - One eligible port: that port wins.
  - Both eligible: the port selected by rr_ptr wins (0=I, 1=D).
- arready_x is combinational and equals 1 only for the winner in the grant cycle. Every other arready is 0.
- Grant cycle actions (all registered):
  - latch the winner's AR fields
  - set arid = port index zero-extended to ID_W (I→0, D→1)
  - save the winner's original arid_x in saved_id_x
  - set pending_x=1
  - set rr_ptr to the non-winner
- arvalid rises in the cycle after arvalid_x is accepted (1-cycle latency).
- AR register holds all fields stable until arvalid&&arready, then empties. No grant occurs in that same cycle, so peak throughput is one AR per 2 cycles.
- R routing is by rid[0]; rid[ID_W-1:1] is ignored.
  - rvalid_x = rvalid && rid[0]==x && pending_x
  - rdata_x, rresp_x, rlast_x are wired directly from the downstream R channel
  - rid_x = saved_id_x
  - rready = rready of the selected port
- Burst completion: rvalid&&rready&&rlast clears pending_x at the clock edge. The port becomes eligible on the following cycle, never in the same cycle.
- Orphan beat (rvalid with the selected port not pending):
  - rready=1, so the beat is consumed and dropped
  - rvalid_x stays 0
  - rerr sets and holds until reset
- Stall handling:
  - rready_x=0 stalls downstream R; no reordering or buffering.
  - arready low for many cycles: the AR register holds; the other port waits. No starvation beyond one burst per port per round.
- Port I pending and port D blocked by the full AR register: D is granted first once the register drains.

Decomposition:
- Shared package axi_pkg (also used by inst_mux and the data-side mux):
  - AXI width constants: LEN_W=4, SIZE_W=3, BURST_W=2, LOCK_W=2, CACHE_W=4, PROT_W=3
  - port index constants: PORT_I=0, PORT_D=1
  - typedef ar_chan_t: packed struct of all AR fields, used for the AR register
- One natural sub-module, rr_arb2: a 2-requester round-robin grant with a priority pointer.
- All other logic (AR register, pending/ID tracking, R routing) stays in the top.

Test Plan:
- Single fetch:
  - Stimulus: port I issues arid_i=5, araddr_i=0x1FC0_0000, arlen_i=3; downstream arready=1; return 4 beats with rid=0.
  - Required: arvalid 1 cycle after the grant with arid=0; rvalid_i on 4 beats, rid_i=5, rlast_i on the 4th; pending_i clears.
- Simultaneous requests:
  - Stimulus: arvalid_i and arvalid_d both high from reset.
  - Required: I granted first (araddr=I's address, arid=0). D is granted on the first empty-register cycle after the AR handshake, with arid=1.
- Round-robin:
  - Stimulus: both ports request continuously, with responses returned promptly.
  - Required: grants alternate I, D, I, D; neither port is granted twice in a row while the other is eligible.
- Blocking:
  - Stimulus: port I re-asserts arvalid_i while its burst is still pending.
  - Required: arready_i stays 0 until the cycle after the rlast handshake.
- Interleaved R with stall:
  - Stimulus: D burst (rid=1) is returned while rready_d=0 for 3 cycles.
  - Required: rready=0 and data is held for those cycles; rvalid_i=0 throughout.
- Orphan and reset:
  - Stimulus: rvalid with rid=1 and no D burst pending; then aresetn=0 mid-burst.
  - Required: the orphan beat is consumed and rerr=1 sticky. The reset clears arvalid, pending and rerr immediately, without waiting for a clock edge.
